// File: rtl/intr_pkg.sv
// intr_pkg: shared constants for the priority interrupt controller.
// Holds the register map, the VECTOR field layout and the FSM state type.
package intr_pkg;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_VEC  = 2'd2;
  localparam logic [1:0] ADDR_EOI  = 2'd3;

  localparam int IS_BIT = 31;
  localparam int ID_MSB = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: combinational priority encoder, lowest index wins.
// Ports: req_i (request vector), valid_o (any set), id_o (winning index).
module intr_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req_i,
  output logic             valid_o,
  output logic [4:0]       id_o
);

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = 5'(i);
    end
  end

endmodule

// File: rtl/intr_controller.sv
// intr_controller: edge-detecting priority interrupt controller with CPU handshake.
// Ports: sys_clk/reset, irq_src, intr_req/intr_ack, io_* register file port.
module intr_controller
  import intr_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  output logic             intr_req,
  input  logic             intr_ack,
  input  logic             io_cs,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [1:0]       io_addr,
  input  logic [31:0]      io_din,
  output logic [31:0]      io_dout
);

  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [4:0]       active_id_q, active_id_d;
  logic             in_service_q, in_service_d;
  logic             intr_req_q, intr_req_d;
  state_e           state_q, state_d;

  logic             wr_en;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] ack_clr;
  logic             win_valid;
  logic [4:0]       win_id;
  logic [31:0]      vec;

  assign wr_en = io_cs & io_wr;
  assign rise  = irq_src & ~irq_q;
  assign w1c   = (wr_en && io_addr == ADDR_PEND)
               ? N_SRC'(io_din) : '0;
  assign ack_clr = (state_q == REQ && intr_ack)
                 ? (N_SRC'(1) << active_id_q) : '0;

  intr_prio_enc #(.N_SRC(N_SRC)) u_enc (
    .req_i   (pend_q & mask_q),
    .valid_o (win_valid),
    .id_o    (win_id)
  );

  // A new edge is OR-ed in last so it beats any clear in the same cycle.
  assign pend_d = (pend_q & ~w1c & ~ack_clr) | rise;
  assign mask_d = (wr_en && io_addr == ADDR_MASK)
                ? N_SRC'(io_din) : mask_q;

  always_comb begin
    state_d      = state_q;
    active_id_d  = active_id_q;
    in_service_d = in_service_q;
    intr_req_d   = intr_req_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          active_id_d = win_id;
          intr_req_d  = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (intr_ack) begin
          intr_req_d   = 1'b0;
          in_service_d = 1'b1;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (wr_en && io_addr == ADDR_EOI) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      irq_q        <= '0;
      mask_q       <= '0;
      pend_q       <= '0;
      active_id_q  <= '0;
      in_service_q <= 1'b0;
      intr_req_q   <= 1'b0;
      state_q      <= IDLE;
    end else begin
      irq_q        <= irq_src;
      mask_q       <= mask_d;
      pend_q       <= pend_d;
      active_id_q  <= active_id_d;
      in_service_q <= in_service_d;
      intr_req_q   <= intr_req_d;
      state_q      <= state_d;
    end
  end

  assign intr_req = intr_req_q;

  always_comb begin
    vec             = '0;
    vec[IS_BIT]     = in_service_q;
    vec[ID_MSB:0]   = active_id_q;
    io_dout         = '0;
    if (io_cs && io_rd) begin
      unique case (io_addr)
        ADDR_MASK: io_dout = 32'(mask_q);
        ADDR_PEND: io_dout = 32'(pend_q);
        ADDR_VEC:  io_dout = vec;
        default:   io_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_controller.sv
// tb_intr_controller: self-checking bench for intr_controller.
// Table vectors, directed corner sequences and a randomized reference model.
module tb_intr_controller;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic        intr_req;
  logic        intr_ack;
  logic        io_cs, io_rd, io_wr;
  logic [1:0]  io_addr;
  logic [31:0] io_din;
  logic [31:0] io_dout;

  int checks = 0;
  int errors = 0;

  intr_controller #(.N_SRC(8)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .irq_src  (irq_src),
    .intr_req (intr_req),
    .intr_ack (intr_ack),
    .io_cs    (io_cs),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_addr  (io_addr),
    .io_din   (io_din),
    .io_dout  (io_dout)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: register contents plus a service phase
  // (0 = waiting, 1 = request outstanding, 2 = being serviced).
  bit [7:0] m_mask, m_pend, m_prev;
  int       m_phase;
  int       m_id;
  bit       m_req;

  function automatic bit [31:0] m_read(input bit [1:0] a);
    case (a)
      2'd0: return {24'h0, m_mask};
      2'd1: return {24'h0, m_pend};
      2'd2: return ((m_phase == 2) ? 32'h8000_0000 : 32'h0)
                   | 32'(m_id);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit [7:0] rise, np, elig;
    bit wr;
    if (reset) begin
      m_mask = 0; m_pend = 0; m_prev = 0;
      m_phase = 0; m_id = 0; m_req = 0;
      return;
    end
    rise = irq_src & ~m_prev;
    m_prev = irq_src;
    wr = io_cs & io_wr;
    np = m_pend;
    if (wr && io_addr == 2'd1) np = np & ~io_din[7:0];
    elig = m_pend & m_mask;
    if (m_phase == 0) begin
      if (elig != 0) begin
        for (int i = 7; i >= 0; i--) if (elig[i]) m_id = i;
        m_req = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (intr_ack) begin
        np[m_id] = 1'b0;
        m_req = 0; m_phase = 2;
      end
    end else begin
      if (wr && io_addr == 2'd3) m_phase = 0;
    end
    np = np | rise;
    if (wr && io_addr == 2'd0) m_mask = io_din[7:0];
    m_pend = np;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge sys_clk);
    #1;
    chk("req_vs_model", 32'(intr_req), 32'(m_req));
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                    input string nm);
    io_cs = 1; io_rd = 1; io_addr = a;
    #1;
    chk(nm, io_dout, exp);
    io_cs = 0; io_rd = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    io_cs = 1; io_wr = 1; io_addr = a; io_din = d;
    tick();
    io_cs = 0; io_wr = 0; io_din = 0;
  endtask

  task automatic ack();
    intr_ack = 1;
    tick();
    intr_ack = 0;
  endtask

  task automatic do_reset();
    reset = 1; irq_src = 0;
    tick(); tick();
    reset = 0;
  endtask

  typedef struct {
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[6];

  initial begin
    reset = 1; irq_src = 0; intr_ack = 0;
    io_cs = 0; io_rd = 0; io_wr = 0; io_addr = 0; io_din = 0;
    do_reset();

    chk("reset_req", 32'(intr_req), 32'h0);
    rd(2'd0, 32'h0, "reset_mask");
    rd(2'd1, 32'h0, "reset_pend");
    rd(2'd2, 32'h0, "reset_vec");

    tbl[0] = '{2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_00FF, "mask_upper"};
    tbl[1] = '{2'd0, 32'h0000_005A, 2'd0, 32'h0000_005A, "mask_rw"};
    tbl[2] = '{2'd3, 32'h0000_1234, 2'd2, 32'h0000_0000, "eoi_idle"};
    tbl[3] = '{2'd2, 32'h0000_FFFF, 2'd2, 32'h0000_0000, "vec_ro"};
    tbl[4] = '{2'd1, 32'h0000_00FF, 2'd1, 32'h0000_0000, "w1c_empty"};
    tbl[5] = '{2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000, "mask_clr"};
    foreach (tbl[i]) begin
      wr(tbl[i].waddr, tbl[i].wdata);
      rd(tbl[i].raddr, tbl[i].exp, tbl[i].nm);
    end
    io_cs = 1; io_rd = 0; io_addr = 2'd0;
    wr(2'd0, 32'h11);
    io_cs = 1; io_rd = 0; io_addr = 2'd0;
    #1;
    chk("dout_idle_zero", io_dout, 32'h0);
    io_cs = 0;
    wr(2'd0, 32'h0);

    // Basic latency and handshake on source 0.
    wr(2'd0, 32'h01);
    irq_src = 8'h01;
    tick();
    chk("lat_t_req", 32'(intr_req), 32'h0);
    rd(2'd1, 32'h01, "lat_pend");
    tick();
    chk("lat_t1_req", 32'(intr_req), 32'h1);
    ack();
    chk("ack_req_low", 32'(intr_req), 32'h0);
    rd(2'd2, 32'h8000_0000, "ack_vec0");
    rd(2'd1, 32'h0, "ack_pend0");
    wr(2'd3, 32'h0);
    irq_src = 0; tick();

    // Two simultaneous edges: priority order 2 then 5.
    wr(2'd0, 32'hFF);
    irq_src = 8'h24;
    tick(); tick();
    chk("dual_req", 32'(intr_req), 32'h1);
    ack();
    rd(2'd2, 32'h8000_0002, "dual_vec2");
    wr(2'd3, 32'h0);
    chk("eoi_req_low", 32'(intr_req), 32'h0);
    tick();
    chk("eoi_rereq", 32'(intr_req), 32'h1);
    ack();
    rd(2'd2, 32'h8000_0005, "dual_vec5");
    wr(2'd3, 32'h0);
    irq_src = 0; tick();

    // Masked source latches but does not request.
    wr(2'd0, 32'h0);
    irq_src = 8'h08;
    tick(); tick();
    rd(2'd1, 32'h08, "masked_pend");
    chk("masked_noreq", 32'(intr_req), 32'h0);
    wr(2'd0, 32'h08);
    chk("unmask_w", 32'(intr_req), 32'h0);
    tick();
    chk("unmask_w1", 32'(intr_req), 32'h1);
    ack();
    wr(2'd3, 32'h0);
    irq_src = 0; tick();

    // Request stays frozen while in REQ.
    wr(2'd0, 32'hFF);
    irq_src = 8'h10;
    tick(); tick();
    irq_src = 8'h12;
    wr(2'd0, 32'h0);
    chk("stable_req", 32'(intr_req), 32'h1);
    tick();
    chk("stable_req2", 32'(intr_req), 32'h1);
    ack();
    rd(2'd2, 32'h8000_0004, "stable_vec4");
    rd(2'd1, 32'h02, "stable_pend");
    wr(2'd3, 32'h0);
    wr(2'd1, 32'h02);
    irq_src = 0; tick();

    // W1C racing a new edge: the edge wins.
    irq_src = 8'h40;
    wr(2'd1, 32'h40);
    rd(2'd1, 32'h40, "w1c_race");
    wr(2'd1, 32'h40);
    rd(2'd1, 32'h00, "w1c_clear");

    // Held-high source sets pending only once.
    tick();
    wr(2'd1, 32'h40);
    tick(); tick();
    rd(2'd1, 32'h00, "held_once");
    irq_src = 0; tick();

    // Ack in IDLE is ignored.
    ack();
    chk("ack_idle_req", 32'(intr_req), 32'h0);
    rd(2'd2, 32'h0000_0004, "ack_idle_vec");

    // EOI in REQ is ignored.
    wr(2'd0, 32'hFF);
    irq_src = 8'h01;
    tick(); tick();
    wr(2'd3, 32'h0);
    chk("eoi_req_ign", 32'(intr_req), 32'h1);
    ack();
    rd(2'd2, 32'h8000_0000, "eoi_req_vec");
    wr(2'd3, 32'h0);

    // Reset while servicing source 3.
    irq_src = 8'h08;
    tick(); tick();
    ack();
    rd(2'd2, 32'h8000_0003, "svc_vec3");
    do_reset();
    chk("rst_svc_req", 32'(intr_req), 32'h0);
    rd(2'd2, 32'h0, "rst_svc_vec");
    rd(2'd0, 32'h0, "rst_svc_mask");
    rd(2'd1, 32'h0, "rst_svc_pend");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0)
        irq_src = irq_src ^ 8'($urandom_range(0, 255));
      intr_ack = ($urandom_range(0, 3) == 0);
      io_cs    = ($urandom_range(0, 1) == 1);
      io_rd    = ($urandom_range(0, 1) == 1);
      io_wr    = ($urandom_range(0, 4) == 0);
      io_addr  = 2'($urandom_range(0, 3));
      io_din   = $urandom;
      #1;
      chk("rand_dout", io_dout,
          (io_cs && io_rd) ? m_read(io_addr) : 32'h0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_controller.md
# intr_controller

Priority interrupt controller between the I/O devices and the CPU's single interrupt line. It edge-detects up to N_SRC device interrupt sources, latches them as pending, and masks them. It picks the highest-priority pending source, then runs the intr_req/intr_ack handshake with the CPU's control unit. The CPU's interrupt service routine reads the active source ID and signals end-of-interrupt through a small register file on the I/O memory port.

## Interface
- N_SRC, 8, number of interrupt sources (1..32); index 0 is highest priority
- sys_clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- irq_src  in  N_SRC  device interrupt lines, rising-edge sensitive, synchronous to sys_clk
- intr_req  out  1  interrupt request to CPU, registered
- intr_ack  in  1  interrupt acknowledge from CPU, one-cycle pulse
- io_cs  in  1  register file select
- io_rd  in  1  register read strobe, qualified by io_cs
- io_wr  in  1  register write strobe, qualified by io_cs
- io_addr  in  2  register select
- io_din  in  32  write data
- io_dout  out  32  read data, combinational, 0 when not (io_cs & io_rd)

## Operation
- Registers, selected by io_addr:
  - 0 MASK: RW, enable per source; reset value 0, so all sources are disabled.
  - 1 PENDING: read returns the pending bits. A write of 1 to a bit clears it (W1C).
  - 2 VECTOR: RO, bit31 = in_service, bits[4:0] = active ID, all other bits 0.
  - 3 EOI: WO, a write of any data ends service.
- Edge detect: irq_q <= irq_src every cycle. A rising edge (irq_src & ~irq_q) sets the matching pending bit.
  - Set and clear in the same cycle, whether by W1C or by ack: set wins.
  - Masked sources still latch pending. They are only blocked from arbitration.
- Arbitration: eligible = pending & MASK. The winner is the lowest set index, from the combinational priority encoder.
- FSM states:
  - IDLE:
    - If eligible is nonzero, latch the winner into active_id, set intr_req <= 1, and go to REQ.
    - intr_ack is ignored in IDLE.
  - REQ:
    - intr_req is held and active_id is frozen. A higher-priority arrival, a MASK change or a W1C of the active bit does not retract the request.
    - On intr_ack: clear pending[active_id], intr_req <= 0, in_service <= 1, go to SERVICE.
  - SERVICE:
    - No new request is issued; there is no nesting.
    - On an EOI write: in_service <= 0, go to IDLE. EOI writes in IDLE or REQ have no effect.
- Edges arriving while in REQ or SERVICE latch into pending and are arbitrated after the return to IDLE.
- N_SRC < 32: upper bits of MASK and PENDING read as 0 and ignore writes.

## Timing
- Reset values: intr_req = 0, MASK = 0, PENDING = 0, irq_q = 0, active_id = 0, in_service = 0, state = IDLE.
- io_dout is 0 whenever it is not being read.
- Reset asserted at any point, including mid-REQ or mid-SERVICE, returns the block to reset values on the next edge.
- Latency, with a rising edge on irq_src first sampled at edge t and the source enabled:
  - pending is set after edge t.
  - intr_req is high after edge t+1, so the request appears 2 cycles after the edge is sampled.
- intr_ack sampled at edge a: intr_req is low and VECTOR.in_service = 1 after edge a.
- EOI write at edge e: state is IDLE after edge e. If another source is eligible, intr_req rises again after edge e+1.
- Register writes take effect at the write edge. A MASK write at edge w affects arbitration from cycle w+1.
- irq_src held high produces only one pending set. Another set requires a low-then-high transition.

## Structure
- Package intr_pkg holds:
  - register address constants: ADDR_MASK = 0, ADDR_PEND = 1, ADDR_VEC = 2, ADDR_EOI = 3
  - FSM state encodings: IDLE, REQ, SERVICE
  - VECTOR field positions: IS_BIT = 31, ID_MSB = 4
- Sub-module: intr_prio_enc. It is combinational and parameterized by N_SRC. Outputs are valid and id[4:0], lowest index first.
- The top level holds the edge detect, the PENDING/MASK registers, the FSM and the read mux.

## Test plan
- Reset, then MASK = 0x01 and a rising edge on irq_src[0]:
  - intr_req rises 2 cycles after the edge is sampled.
  - intr_ack pulse: intr_req falls, VECTOR reads 0x8000_0000, PENDING = 0.
- Simultaneous edges on irq_src[5] and irq_src[2] with MASK = 0xFF:
  - Pulse intr_ack: VECTOR = 0x8000_0002.
  - EOI: intr_req returns 2 cycles later.
  - Pulse intr_ack again: VECTOR = 0x8000_0005.
- Masked source: MASK = 0, edge on irq_src[3]:
  - PENDING = 0x08 and intr_req stays 0.
  - Write MASK = 0x08: intr_req = 1 after the following edge.
- Request stability: in REQ for source 4, assert an edge on source 1 and write MASK = 0.
  - intr_req stays high and ack yields ID 4.
  - PENDING = 0x02.
- Boundaries:
  - W1C of bit 6 on the same cycle as a new irq_src[6] edge: bit 6 remains set.
  - intr_ack in IDLE: no effect.
  - EOI in REQ: no effect.
- Reset mid-SERVICE (IDs 0x8000_0003): next cycle intr_req = 0, VECTOR = 0, MASK = 0, PENDING = 0.
